// File: rtl/scs8hd_scan_pkg.sv
// scs8hd_scan_pkg: shared FSM states, chain constants and masked-NAND helper
package scs8hd_scan_pkg;

    localparam int MAX_N = 16;
    localparam int SCAN_CHAIN_EXTRA = 1;

    typedef enum logic [1:0] {
        FUNC  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } scan_state_e;

    // Unused upper lanes must be padded with vec=1, mask=0 so they do not affect the AND.
    function automatic logic nand_masked(input logic [MAX_N-1:0] vec, input logic [MAX_N-1:0] mask);
        return ~&(vec ^ mask);
    endfunction

endpackage

// File: rtl/scs8hd_pg_gate.sv
// scs8hd_pg_gate: forces outputs to X while power pins are not good (SC_USE_PG_PIN_EN only)
module scs8hd_pg_gate (
    input  logic y_in,
    input  logic scq_in,
    input  logic vld_in,
    input  logic vpwr,
    input  logic vgnd,
    output logic y,
    output logic scq,
    output logic vld
);

    logic pg_ok;

    // Outputs are only trustworthy with vpwr solidly high and vgnd solidly low.
    always_comb begin
        pg_ok = (vpwr === 1'b1) && (vgnd === 1'b0);
        y     = pg_ok ? y_in   : 1'bx;
        scq   = pg_ok ? scq_in : 1'bx;
        vld   = pg_ok ? vld_in : 1'bx;
    end

endmodule

// File: rtl/scs8hd_nandn_scan_reg.sv
// scs8hd_nandn_scan_reg: registered masked N-input NAND with scan chain; optional power pins via SC_USE_PG_PIN_EN
module scs8hd_nandn_scan_reg
    import scs8hd_scan_pkg::*;
#(
    parameter int N = 4,
    parameter logic [N-1:0] INV_MASK = N'(4'b0011)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [N-1:0] A,
    input  logic         DE,
    input  logic         SCE,
    input  logic         SCD,
    output logic         Y,
    output logic         VLD,
    output logic         SCQ,
`ifdef SC_USE_PG_PIN_EN
    input  logic         vpwr,
    input  logic         vgnd,
    input  logic         vpb,
    input  logic         vnb,
`endif
    output logic         SCAN_FULL
);

    localparam int CNT_W = $clog2(N + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N + SCAN_CHAIN_EXTRA);

    scan_state_e      state_q, state_d;
    logic [N-1:0]     in_reg, in_d;
    logic             in_vld, iv_d;
    logic             y_reg, y_d;
    logic             vld_reg, v_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [MAX_N-1:0] vec, msk;

    // Next-state and datapath: scan shift wins over everything but reset; SHIFT drops into a one-cycle HOLD.
    always_comb begin
        state_d = state_q;
        in_d    = in_reg;
        iv_d    = in_vld;
        y_d     = y_reg;
        v_d     = vld_reg;
        cnt_d   = cnt;
        vec     = {MAX_N{1'b1}};
        vec[N-1:0] = in_reg;
        msk     = '0;
        msk[N-1:0] = INV_MASK;
        if (SCE) begin
            state_d = SHIFT;
            in_d    = {in_reg[N-2:0], SCD};
            y_d     = in_reg[N-1];
            iv_d    = 1'b0;
            v_d     = 1'b0;
            cnt_d   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end else if (state_q == SHIFT) begin
            state_d = HOLD;
            cnt_d   = '0;
            iv_d    = 1'b1;
            v_d     = 1'b0;
        end else begin
            state_d = FUNC;
            in_d    = DE ? A : in_reg;
            iv_d    = DE;
            y_d     = nand_masked(vec, msk);
            v_d     = in_vld;
        end
    end

    // State, chain and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= FUNC;
            in_reg  <= '0;
            in_vld  <= 1'b0;
            y_reg   <= 1'b1;
            vld_reg <= 1'b0;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            in_reg  <= in_d;
            in_vld  <= iv_d;
            y_reg   <= y_d;
            vld_reg <= v_d;
            cnt     <= cnt_d;
        end
    end

    assign SCAN_FULL = (cnt == CNT_MAX);

`ifdef SC_USE_PG_PIN_EN
    logic unused_pg;
    assign unused_pg = vpb ^ vnb;

    scs8hd_pg_gate u_pg (
        .y_in   (y_reg),
        .scq_in (y_reg),
        .vld_in (vld_reg),
        .vpwr   (vpwr),
        .vgnd   (vgnd),
        .y      (Y),
        .scq    (SCQ),
        .vld    (VLD)
    );
`else
    assign Y   = y_reg;
    assign SCQ = y_reg;
    assign VLD = vld_reg;
`endif

endmodule
